key_candidate_scanner: RTL and testbench
========================================

Name: key_candidate_scanner

Overview:
Sequential consumer of the 16-way 128-bit candidate multiplexer. It drives the mux select through all 16 key candidates and registers each selected candidate. Each candidate goes to an external AES encryption core over a valid/ready handshake, with the latched plaintext. The block compares the returned ciphertext against the known target ciphertext and reports the first matching key index, that key, and the total match count.

Parameters:
DATA_W, 128, width of key, plaintext and ciphertext
NUM_CAND, 16, number of candidates scanned per run
SEL_W, 4, width of the mux select; NUM_CAND must equal 2**SEL_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a scan; ignored while busy=1
plaintext  input  DATA_W  known plaintext; latched on an accepted start
target_ct  input  DATA_W  known ciphertext; latched on an accepted start
mux_sel  output  SEL_W  candidate select driven to the multiplexer
mux_data  input  DATA_W  selected candidate returned from the multiplexer (combinational path)
enc_valid  output  1  key/plaintext offer to the AES core
enc_ready  input  1  AES core accepts the offer
enc_key  output  DATA_W  registered candidate key
enc_pt  output  DATA_W  latched plaintext
enc_ct_valid  input  1  AES core result strobe, one cycle
enc_ct  input  DATA_W  AES core ciphertext result
busy  output  1  scan in progress
done  output  1  one-cycle pulse at scan completion
found  output  1  at least one candidate matched in the last scan
key_index  output  SEL_W  index of the first matching candidate
key_out  output  DATA_W  first matching key
match_count  output  SEL_W+1  number of matching candidates, 0..16

Behaviour:
- Reset values: all outputs 0 (mux_sel=0, enc_valid=0, busy=0, done=0, found=0, key_index=0, key_out=0, match_count=0, enc_key=0, enc_pt=0). Internal latches are cleared. The FSM goes to IDLE.
- FSM states: IDLE, SELECT, ISSUE, WAIT, COMPARE, DONE.
- IDLE:
  - start=1 latches plaintext and target_ct, sets mux_sel=0, and clears found, key_index, key_out and match_count.
  - busy goes high next cycle; next state is SELECT.
- SELECT: one cycle. mux_sel is stable and mux_data is captured into enc_key at the clock edge. Next state is ISSUE.
- ISSUE:
  - enc_valid=1. enc_key and enc_pt are held constant until the handshake completes.
  - The transfer occurs in any cycle with enc_valid && enc_ready.
  - enc_valid deasserts in the following cycle; next state is WAIT.
  - enc_valid never drops before the handshake completes.
- WAIT:
  - Waits for enc_ct_valid and registers enc_ct on it; next state is COMPARE.
  - There is no timeout.
  - enc_ct_valid in any other state is ignored.
- COMPARE: full DATA_W equality between the registered ciphertext and the latched target.
  - On a match, match_count increments.
  - On a match with found=0: set found=1, key_index=mux_sel, key_out=enc_key.
  - Later matches do not overwrite key_index or key_out.
  - If mux_sel==NUM_CAND-1, next state is DONE. Otherwise mux_sel increments and the next state is SELECT. mux_sel never wraps during a scan.
- DONE:
  - done=1 for exactly one cycle; busy deasserts in the same cycle done is asserted.
  - Next state is IDLE.
  - Results (found, key_index, key_out, match_count) hold until the next accepted start.
- Per-candidate latency is 4 cycles plus the ready wait plus the core latency. The minimum full scan is 16×(SELECT+ISSUE+WAIT+COMPARE) plus the core latency per candidate, plus 1 DONE cycle.
- Simultaneous events:
  - start during busy or in the DONE cycle is ignored.
  - start in IDLE in the same cycle as a stale enc_ct_valid: the result strobe is ignored.
- Reset mid-scan: an immediate asynchronous return to the reset values. No done pulse is generated and partial results are discarded.
- match_count width is SEL_W+1 so that 16 matches cannot overflow.

Decomposition:
- Shared package (aes_kr_pkg):
  - DATA_W and NUM_CAND constants
  - a block_t typedef for 128-bit key and data vectors
  - the FSM state enum scan_state_t
- One natural sub-module: ct_compare, a registered 128-bit equality comparator with a valid-in/valid-out strobe. It keeps the wide compare off the FSM's critical path.
- Everything else stays in the top level.

Test Plan:
- Single match: candidate 5 = K, AES model returns target_ct only for K, ready always high → done after 16 candidates, found=1, key_index=5, key_out=K, match_count=1.
- No match: all 16 candidates wrong → done pulse, found=0, key_index=0, key_out=0, match_count=0.
- Multiple matches: candidates 3, 9 and 15 match → key_index=3, key_out=candidate 3, match_count=3; the index-15 match does not overwrite.
- Backpressure: enc_ready held low for 7 cycles on candidate 0 → enc_valid stays high and enc_key stays stable throughout, exactly one transfer, scan still completes correctly.
- start while busy: pulse start at candidate 8 → ignored, with no restart and no result clear. A spurious enc_ct_valid in IDLE → no state change.
- Reset mid-scan: assert rst_n=0 during WAIT at candidate 10 → all outputs 0 immediately, no done pulse. A fresh start afterwards runs a full 16-candidate scan.

Source files
------------

// File: rtl/key_candidate_scanner_pkg.sv
// Shared constants, payload types and scan FSM encoding for the key candidate scanner.
package key_candidate_scanner_pkg;

   localparam int unsigned DATA_W   = 128;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned NUM_CAND = 1 << SEL_W;

   typedef logic [DATA_W-1:0] block_t;
   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [SEL_W:0]    count_t;

   localparam sel_t LAST_SEL = sel_t'(NUM_CAND - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } scan_state_t;

endpackage

// File: rtl/key_candidate_scanner_if.sv
// Scanner-side bundle: control/result, candidate mux and AES core handshake.
interface key_candidate_scanner_if;
   import key_candidate_scanner_pkg::*;

   logic   start;
   block_t plaintext;
   block_t target_ct;
   sel_t   mux_sel;
   block_t mux_data;
   logic   enc_valid;
   logic   enc_ready;
   block_t enc_key;
   block_t enc_pt;
   logic   enc_ct_valid;
   block_t enc_ct;
   logic   busy;
   logic   done;
   logic   found;
   sel_t   key_index;
   block_t key_out;
   count_t match_count;

   modport master (
      input  start, plaintext, target_ct, mux_data, enc_ready, enc_ct_valid, enc_ct,
      output mux_sel, enc_valid, enc_key, enc_pt, busy, done, found, key_index,
             key_out, match_count
   );

   modport slave (
      output start, plaintext, target_ct, mux_data, enc_ready, enc_ct_valid, enc_ct,
      input  mux_sel, enc_valid, enc_key, enc_pt, busy, done, found, key_index,
             key_out, match_count
   );

endinterface

// File: rtl/key_candidate_scanner_ct_compare.sv
// Registered wide equality compare; result and strobe appear one cycle after valid_i.
module key_candidate_scanner_ct_compare
   import key_candidate_scanner_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   valid_i,
   input  block_t a_i,
   input  block_t b_i,
   output logic   valid_o,
   output logic   match_o
);

   logic valid_q;
   logic match_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
         match_q <= valid_i && (a_i == b_i);
      end
   end

   assign valid_o = valid_q;
   assign match_o = match_q;

endmodule

// File: rtl/key_candidate_scanner.sv
// Walks all key candidates through the AES core and records the first match and match count.
module key_candidate_scanner
   import key_candidate_scanner_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   key_candidate_scanner_if.master scan_if
);

   scan_state_t state_q, state_d;
   sel_t        mux_sel_q, mux_sel_d;
   logic        enc_valid_q, enc_valid_d;
   block_t      enc_key_q, enc_key_d;
   block_t      pt_q, pt_d;
   block_t      tgt_q, tgt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        found_q, found_d;
   sel_t        key_index_q, key_index_d;
   block_t      key_out_q, key_out_d;
   count_t      match_count_q, match_count_d;

   logic        ct_hit_c;
   logic        cmp_valid;
   logic        cmp_match;

   // Result strobes are only honoured while waiting on the core.
   assign ct_hit_c = (state_q == S_WAIT) && scan_if.enc_ct_valid;

   key_candidate_scanner_ct_compare u_ct_compare (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (ct_hit_c),
      .a_i     (scan_if.enc_ct),
      .b_i     (tgt_q),
      .valid_o (cmp_valid),
      .match_o (cmp_match)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mux_sel_q     <= '0;
         enc_valid_q   <= 1'b0;
         enc_key_q     <= '0;
         pt_q          <= '0;
         tgt_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         key_index_q   <= '0;
         key_out_q     <= '0;
         match_count_q <= '0;
      end else begin
         state_q       <= state_d;
         mux_sel_q     <= mux_sel_d;
         enc_valid_q   <= enc_valid_d;
         enc_key_q     <= enc_key_d;
         pt_q          <= pt_d;
         tgt_q         <= tgt_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         found_q       <= found_d;
         key_index_q   <= key_index_d;
         key_out_q     <= key_out_d;
         match_count_q <= match_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mux_sel_d     = mux_sel_q;
      enc_valid_d   = enc_valid_q;
      enc_key_d     = enc_key_q;
      pt_d          = pt_q;
      tgt_d         = tgt_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      found_d       = found_q;
      key_index_d   = key_index_q;
      key_out_d     = key_out_q;
      match_count_d = match_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (scan_if.start) begin
               pt_d          = scan_if.plaintext;
               tgt_d         = scan_if.target_ct;
               mux_sel_d     = '0;
               found_d       = 1'b0;
               key_index_d   = '0;
               key_out_d     = '0;
               match_count_d = '0;
               busy_d        = 1'b1;
               state_d       = S_SELECT;
            end
         end
         S_SELECT: begin
            enc_key_d   = scan_if.mux_data;
            enc_valid_d = 1'b1;
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            // enc_valid_q is high throughout this state, so ready alone completes the transfer.
            if (scan_if.enc_ready) begin
               enc_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ct_hit_c) begin
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (cmp_valid && cmp_match) begin
               match_count_d = match_count_q + count_t'(1);
               if (!found_q) begin
                  found_d     = 1'b1;
                  key_index_d = mux_sel_q;
                  key_out_d   = enc_key_q;
               end
            end
            if (mux_sel_q == LAST_SEL) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               mux_sel_d = mux_sel_q + sel_t'(1);
               state_d   = S_SELECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign scan_if.mux_sel     = mux_sel_q;
   assign scan_if.enc_valid   = enc_valid_q;
   assign scan_if.enc_key     = enc_key_q;
   assign scan_if.enc_pt      = pt_q;
   assign scan_if.busy        = busy_q;
   assign scan_if.done        = done_q;
   assign scan_if.found       = found_q;
   assign scan_if.key_index   = key_index_q;
   assign scan_if.key_out     = key_out_q;
   assign scan_if.match_count = match_count_q;

endmodule

// File: tb/tb_key_candidate_scanner.sv
// Randomized bench: toy cipher core, candidate table and a whole-scan reference model.
module tb_key_candidate_scanner;
   import key_candidate_scanner_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   key_candidate_scanner_if bus ();

   key_candidate_scanner dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (bus)
   );

   block_t cand [NUM_CAND];
   assign bus.mux_data = cand[bus.mux_sel];

   int     n_total = 0;
   int     n_bad   = 0;
   block_t cur_pt, cur_tgt, exp_pt;
   int     e_count, e_idx;
   bit     e_found;
   block_t e_key;
   int     xfer_cnt = 0;
   int     epoch = 0;
   int     max_lat = 3;
   int     bp_hold = 0;
   bit     ready_rand = 1'b0;
   bit     ct_pending = 1'b0;
   int     v0_cycles = 0;

   task automatic check_eq(input string tag, input block_t got, input block_t exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic block_t toy_enc(input block_t k, input block_t p);
      return p ^ {k[63:0], k[63:0]};
   endfunction

   function automatic block_t rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Toy AES core: accepts on valid&&ready, answers after a random latency.
   initial begin : aes_core
      block_t k, p;
      int lat, ep;
      bus.enc_ct_valid = 1'b0;
      bus.enc_ct = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.enc_valid && bus.enc_ready) begin
            k = bus.enc_key;
            p = bus.enc_pt;
            check_eq("enc_pt", p, exp_pt);
            ep = epoch;
            lat = $urandom_range(1, max_lat);
            xfer_cnt++;
            @(posedge clk);
            ct_pending = 1'b1;
            repeat (lat - 1) @(posedge clk);
            #1;
            if (ep == epoch) begin
               bus.enc_ct_valid = 1'b1;
               bus.enc_ct = toy_enc(k, p);
            end
            @(posedge clk);
            #1;
            bus.enc_ct_valid = 1'b0;
            ct_pending = 1'b0;
         end
      end
   end

   initial begin : ready_drv
      bus.enc_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.enc_valid && bp_hold > 0) begin
            bus.enc_ready = 1'b0;
            bp_hold--;
         end else begin
            bus.enc_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // An offer that was not taken must persist unchanged on the next cycle.
   bit     pend = 1'b0;
   block_t pkey;
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check_eq("valid_hold", block_t'(bus.enc_valid), block_t'(1'b1));
            check_eq("key_hold", bus.enc_key, pkey);
         end
         pend = bus.enc_valid && !bus.enc_ready;
         pkey = bus.enc_key;
         if (bus.enc_valid && bus.mux_sel == '0) v0_cycles++;
      end
   end

   task automatic check_zero(input string tag);
      check_eq({tag, "_mux_sel"},   block_t'(bus.mux_sel),     '0);
      check_eq({tag, "_enc_valid"}, block_t'(bus.enc_valid),   '0);
      check_eq({tag, "_busy"},      block_t'(bus.busy),        '0);
      check_eq({tag, "_done"},      block_t'(bus.done),        '0);
      check_eq({tag, "_found"},     block_t'(bus.found),       '0);
      check_eq({tag, "_key_index"}, block_t'(bus.key_index),   '0);
      check_eq({tag, "_key_out"},   bus.key_out,               '0);
      check_eq({tag, "_count"},     block_t'(bus.match_count), '0);
      check_eq({tag, "_enc_key"},   bus.enc_key,               '0);
      check_eq({tag, "_enc_pt"},    bus.enc_pt,                '0);
   endtask

   task automatic setup(input logic [15:0] mset);
      block_t base, r;
      base = rnd();
      cur_pt = rnd();
      cur_tgt = toy_enc(base, cur_pt);
      for (int i = 0; i < int'(NUM_CAND); i++) begin
         r = rnd();
         if (mset[i]) begin
            cand[i] = {r[127:64], base[63:0]};
         end else begin
            if (r[63:0] == base[63:0]) r[0] = ~r[0];
            cand[i] = r;
         end
      end
   endtask

   task automatic run_scan(input string tag, input int inject_at, input int reset_at,
                           input bit stale_start);
      bit got_done, injected;
      e_count = 0; e_found = 1'b0; e_idx = 0; e_key = '0;
      for (int i = 0; i < int'(NUM_CAND); i++) begin
         if (toy_enc(cand[i], cur_pt) == cur_tgt) begin
            e_count++;
            if (!e_found) begin e_found = 1'b1; e_idx = i; e_key = cand[i]; end
         end
      end
      exp_pt = cur_pt;
      xfer_cnt = 0;
      v0_cycles = 0;
      got_done = 1'b0;
      injected = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.plaintext = cur_pt;
      bus.target_ct = cur_tgt;
      if (stale_start) begin bus.enc_ct_valid = 1'b1; bus.enc_ct = cur_tgt; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (stale_start) bus.enc_ct_valid = 1'b0;
      bus.plaintext = rnd();
      bus.target_ct = rnd();
      @(negedge clk);
      check_eq({tag, "_busy_on"}, block_t'(bus.busy), block_t'(1'b1));
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (bus.done) begin got_done = 1'b1; break; end
         if (inject_at >= 0 && !injected && int'(bus.mux_sel) == inject_at) begin
            injected = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.plaintext = ~cur_pt;
            bus.target_ct = ~cur_tgt;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            check_eq({tag, "_busy_kept"}, block_t'(bus.busy), block_t'(1'b1));
            check_eq({tag, "_sel_kept"}, block_t'(int'(bus.mux_sel) >= inject_at),
                     block_t'(1'b1));
         end
         if (reset_at >= 0 && ct_pending && int'(bus.mux_sel) == reset_at) begin
            rst_n = 1'b0;
            epoch++;
            #1;
            check_zero({tag, "_rst"});
            repeat (3) begin
               @(negedge clk);
               check_eq({tag, "_no_done"}, block_t'(bus.done), '0);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
      end
      check_eq({tag, "_done_seen"}, block_t'(got_done), block_t'(1'b1));
      if (got_done) begin
         check_eq({tag, "_busy_at_done"}, block_t'(bus.busy), '0);
         check_eq({tag, "_found"}, block_t'(bus.found), block_t'(e_found));
         check_eq({tag, "_key_index"}, block_t'(bus.key_index), block_t'(e_idx));
         check_eq({tag, "_key_out"}, bus.key_out, e_key);
         check_eq({tag, "_count"}, block_t'(bus.match_count), block_t'(e_count));
         check_eq({tag, "_xfers"}, block_t'(xfer_cnt), block_t'(NUM_CAND));
         @(negedge clk);
         check_eq({tag, "_done_pulse"}, block_t'(bus.done), '0);
         check_eq({tag, "_busy_off"}, block_t'(bus.busy), '0);
      end
   endtask

   initial begin : watchdog
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "timeout");
   end

   initial begin : main
      bus.start = 1'b0;
      bus.plaintext = '0;
      bus.target_ct = '0;
      for (int i = 0; i < int'(NUM_CAND); i++) cand[i] = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      setup(16'h0020);
      run_scan("single", -1, -1, 1'b0);
      check_eq("single_idx5", block_t'(bus.key_index), block_t'(5));

      setup(16'h0000);
      run_scan("nomatch", -1, -1, 1'b0);

      setup(16'h8208);
      run_scan("multi", -1, -1, 1'b0);
      check_eq("multi_idx3", block_t'(bus.key_index), block_t'(3));

      // Stray result strobe while idle: nothing may move.
      repeat (3) @(posedge clk);
      #1 bus.enc_ct_valid = 1'b1; bus.enc_ct = cur_tgt;
      @(posedge clk); #1 bus.enc_ct_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("idle_strobe_busy", block_t'(bus.busy), '0);
      check_eq("idle_strobe_count", block_t'(bus.match_count), block_t'(e_count));
      check_eq("idle_strobe_key", bus.key_out, e_key);

      setup(16'($urandom_range(0, 65535)));
      bp_hold = 7;
      run_scan("bp", -1, -1, 1'b0);
      check_eq("bp_valid_cycles", block_t'(v0_cycles), block_t'(8));

      setup(16'($urandom_range(0, 65535)));
      run_scan("busy_start", 8, -1, 1'b1);

      setup(16'($urandom_range(0, 65535)));
      max_lat = 4;
      run_scan("midreset", -1, 10, 1'b0);
      max_lat = 3;
      setup(16'($urandom_range(0, 65535)));
      run_scan("after_reset", -1, -1, 1'b0);

      ready_rand = 1'b1;
      for (int s = 0; s < 4; s++) begin
         setup(16'($urandom_range(0, 65535)));
         run_scan("rand", -1, -1, 1'b0);
      end
      setup(16'hFFFF);
      run_scan("all", -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
